// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks,
// appends 0x80, zero fill and the 64-bit big-endian bit length.
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         blk_start,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_final,
    input  logic         blk_finish,
    output logic         msg_done
);

    typedef enum logic [2:0] {
        FILL,
        PAD,
        LEN,
        ISSUE,
        WAIT
    } state_t;

    state_t             state;
    logic [511:0]       buffer;
    logic [5:0]         idx;
    logic [LEN_W-1:0]   bitlen;
    logic               first;
    logic               is_final;
    logic               pad_pending;
    logic               len_pending;
    logic [63:0]        len64;
    logic [8:0]         pos;

    // Bit length zero-extended into the trailing length field.
    assign len64    = 64'(bitlen);
    // Byte idx lives at bit (63-idx)*8; 63-idx is ~idx for 6 bits.
    assign pos      = {~idx, 3'b000};
    // Only accept bytes while filling; forced low while in reset.
    assign in_ready = reset && (state == FILL);
    assign blk_data = buffer;

    // Block assembly FSM with registered block-interface outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= FILL;
            buffer      <= '0;
            idx         <= '0;
            bitlen      <= '0;
            first       <= 1'b1;
            is_final    <= 1'b0;
            pad_pending <= 1'b0;
            len_pending <= 1'b0;
            blk_start   <= 1'b0;
            blk_first   <= 1'b0;
            blk_final   <= 1'b0;
            msg_done    <= 1'b0;
        end else begin
            blk_start <= 1'b0;
            msg_done  <= 1'b0;
            unique case (state)
                FILL: begin
                    if (in_valid) begin
                        buffer[pos +: 8] <= in_data;
                        bitlen <= bitlen + LEN_W'(8);
                        if (idx == 6'd63) begin
                            state     <= ISSUE;
                            blk_start <= 1'b1;
                            blk_first <= first;
                            blk_final <= 1'b0;
                            is_final  <= 1'b0;
                            if (in_last) begin
                                pad_pending <= 1'b1;
                            end
                        end else begin
                            idx <= idx + 6'd1;
                            if (in_last) begin
                                state <= PAD;
                            end
                        end
                    end
                end
                PAD: begin
                    buffer[pos +: 8] <= 8'h80;
                    if (idx <= 6'd55) begin
                        buffer[63:0] <= len64;
                        is_final     <= 1'b1;
                        blk_final    <= 1'b1;
                    end else begin
                        len_pending <= 1'b1;
                        is_final    <= 1'b0;
                        blk_final   <= 1'b0;
                    end
                    blk_start <= 1'b1;
                    blk_first <= first;
                    state     <= ISSUE;
                end
                LEN: begin
                    buffer[63:0] <= len64;
                    is_final     <= 1'b1;
                    blk_final    <= 1'b1;
                    blk_first    <= first;
                    blk_start    <= 1'b1;
                    state        <= ISSUE;
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (blk_finish) begin
                        buffer    <= '0;
                        blk_first <= 1'b0;
                        blk_final <= 1'b0;
                        first     <= 1'b0;
                        if (is_final) begin
                            msg_done    <= 1'b1;
                            bitlen      <= '0;
                            idx         <= '0;
                            first       <= 1'b1;
                            is_final    <= 1'b0;
                            pad_pending <= 1'b0;
                            len_pending <= 1'b0;
                            state       <= FILL;
                        end else if (pad_pending) begin
                            idx         <= '0;
                            pad_pending <= 1'b0;
                            state       <= PAD;
                        end else if (len_pending) begin
                            len_pending <= 1'b0;
                            state       <= LEN;
                        end else begin
                            idx   <= '0;
                            state <= FILL;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: padded blocks are predicted from the
// raw message, queued, and compared as each blk_start appears.
module tb_sha256_msg_padder;

    typedef struct {
        logic [511:0] d;
        logic         f;
        logic         l;
    } blk_t;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_ready;
    logic         blk_start;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_final;
    logic         blk_finish;
    logic         msg_done;

    int errors = 0;
    int checks = 0;
    int nstart = 0;
    int ndone  = 0;
    int fin_delay = 2;
    bit auto_fin  = 1;

    blk_t       sb[$];
    logic [7:0] msgq[$];

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .blk_start  (blk_start),
        .blk_data   (blk_data),
        .blk_first  (blk_first),
        .blk_final  (blk_final),
        .blk_finish (blk_finish),
        .msg_done   (msg_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Scoreboard monitor: pop expected block on every blk_start.
    initial begin
        blk_t e;
        forever begin
            @(negedge clock);
            if (msg_done) ndone++;
            if (blk_start) begin
                nstart++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: blk_start with no block expected");
                end else begin
                    e = sb.pop_front();
                    if (blk_data !== e.d) begin
                        errors++;
                        $display("FAIL sb_data: got %h want %h", blk_data, e.d);
                    end
                    checks++;
                    if (blk_first !== e.f) begin
                        errors++;
                        $display("FAIL sb_first: got %b want %b", blk_first, e.f);
                    end
                    checks++;
                    if (blk_final !== e.l) begin
                        errors++;
                        $display("FAIL sb_final: got %b want %b", blk_final, e.l);
                    end
                end
            end
        end
    end

    // Core stand-in: pulse blk_finish fin_delay cycles after blk_start.
    initial begin
        int cnt;
        blk_finish = 1'b0;
        forever begin
            @(negedge clock);
            if (blk_start && auto_fin) begin
                cnt = 0;
                while (cnt < fin_delay && reset) begin
                    @(negedge clock);
                    cnt++;
                end
                if (reset && auto_fin) begin
                    blk_finish = 1'b1;
                    @(negedge clock);
                    blk_finish = 1'b0;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference padding of msgq into expected blocks.
    task automatic build_expect();
        logic [7:0]  p[$];
        logic [63:0] bl;
        int          nb;
        blk_t        e;
        p  = msgq;
        bl = 64'(msgq.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int j = 7; j >= 0; j--) p.push_back(bl[8*j +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            e.d = '0;
            for (int j = 0; j < 64; j++) e.d[511-8*j -: 8] = p[64*b+j];
            e.f = (b == 0);
            e.l = (b == nb - 1);
            sb.push_back(e);
        end
    endtask

    // Drive msgq; lat = edges after the last-accept edge until blk_start.
    task automatic send_msg(output int lat);
        int   i;
        int   t;
        logic ok;
        i = 0;
        t = 0;
        while (i < msgq.size() && t < 1000) begin
            in_valid = 1'b1;
            in_data  = msgq[i];
            in_last  = (i == msgq.size() - 1);
            ok = in_ready;
            @(posedge clock);
            if (ok) i++;
            @(negedge clock);
            t++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        checks++;
        if (i != msgq.size()) begin
            errors++;
            $display("FAIL send: accepted %0d bytes want %0d", i, msgq.size());
        end
        lat = 0;
        while (!blk_start && lat < 10) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({in_ready, blk_start, blk_first, blk_final, msg_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outs: got %b want 00000",
                     {in_ready, blk_start, blk_first, blk_final, msg_done});
        end
        checks++;
        if (blk_data !== 512'b0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", blk_data);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_abc();
        int lat;
        int n0;
        int t;
        n0 = ndone;
        fin_delay = 2;
        msgq = '{8'h61, 8'h62, 8'h63};
        build_expect();
        send_msg(lat);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL abc_latency: got %0d want 1", lat);
        end
        t = 0;
        while (ndone < n0 + 1 && t < 3000) begin
            @(negedge clock);
            t++;
        end
        repeat (3) @(negedge clock);
        checks++;
        if (ndone != n0 + 1) begin
            errors++;
            $display("FAIL abc_done: got %0d pulses want 1", ndone - n0);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL abc_sb: %0d blocks left want 0", sb.size());
        end
    endtask

    task automatic test_len55();
        int lat;
        int n0;
        int t;
        n0 = ndone;
        msgq.delete();
        for (int i = 0; i < 55; i++) msgq.push_back(8'(i + 1));
        build_expect();
        send_msg(lat);
        checks++;
        if (blk_final !== 1'b1) begin
            errors++;
            $display("FAIL len55_final: got %b want 1", blk_final);
        end
        t = 0;
        while (ndone < n0 + 1 && t < 3000) begin
            @(negedge clock);
            t++;
        end
        checks++;
        if (ndone != n0 + 1 || sb.size() != 0) begin
            errors++;
            $display("FAIL len55_done: pulses %0d left %0d want 1 0",
                     ndone - n0, sb.size());
        end
    endtask

    task automatic test_len56();
        int lat;
        int n0;
        int s0;
        int t;
        n0 = ndone;
        s0 = nstart;
        msgq.delete();
        for (int i = 0; i < 56; i++) msgq.push_back(8'(8'hA0 ^ i));
        build_expect();
        send_msg(lat);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL len56_latency: got %0d want 1", lat);
        end
        t = 0;
        while (ndone < n0 + 1 && t < 3000) begin
            @(negedge clock);
            t++;
        end
        checks++;
        if (nstart - s0 != 2 || sb.size() != 0) begin
            errors++;
            $display("FAIL len56_blocks: starts %0d left %0d want 2 0",
                     nstart - s0, sb.size());
        end
    endtask

    task automatic test_len64_holdoff();
        int           lat;
        int           n0;
        int           s0;
        int           t;
        int           bad_rdy;
        int           bad_dat;
        logic [511:0] snap;
        n0 = ndone;
        s0 = nstart;
        fin_delay = 20;
        msgq.delete();
        for (int i = 0; i < 64; i++) msgq.push_back(8'(3 * i + 7));
        build_expect();
        send_msg(lat);
        checks++;
        if (lat != 0) begin
            errors++;
            $display("FAIL len64_latency: got %0d want 0", lat);
        end
        snap    = blk_data;
        bad_rdy = 0;
        bad_dat = 0;
        repeat (19) begin
            @(negedge clock);
            if (in_ready !== 1'b0) bad_rdy++;
            if (blk_data !== snap) bad_dat++;
        end
        checks++;
        if (bad_rdy != 0) begin
            errors++;
            $display("FAIL hold_ready: %0d cycles ready want 0", bad_rdy);
        end
        checks++;
        if (bad_dat != 0) begin
            errors++;
            $display("FAIL hold_data: %0d cycles changed want 0", bad_dat);
        end
        checks++;
        if (nstart - s0 != 1) begin
            errors++;
            $display("FAIL hold_starts: got %0d want 1", nstart - s0);
        end
        t = 0;
        while (ndone < n0 + 1 && t < 3000) begin
            @(negedge clock);
            t++;
        end
        checks++;
        if (nstart - s0 != 2 || sb.size() != 0 || ndone != n0 + 1) begin
            errors++;
            $display("FAIL len64_blocks: starts %0d left %0d done %0d want 2 0 1",
                     nstart - s0, sb.size(), ndone - n0);
        end
        fin_delay = 2;
    endtask

    task automatic test_back_to_back();
        int lat;
        int n0;
        int s0;
        int t;
        n0 = ndone;
        s0 = nstart;
        fin_delay = 5;
        msgq = '{8'h61};
        build_expect();
        send_msg(lat);
        msgq = '{8'h62};
        build_expect();
        send_msg(lat);
        t = 0;
        while (ndone < n0 + 2 && t < 3000) begin
            @(negedge clock);
            t++;
        end
        repeat (3) @(negedge clock);
        checks++;
        if (ndone != n0 + 2) begin
            errors++;
            $display("FAIL b2b_done: got %0d pulses want 2", ndone - n0);
        end
        checks++;
        if (nstart - s0 != 2 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_blocks: starts %0d left %0d want 2 0",
                     nstart - s0, sb.size());
        end
        fin_delay = 2;
    endtask

    task automatic test_reset_abort();
        int lat;
        int s0;
        auto_fin = 0;
        msgq.delete();
        for (int i = 0; i < 56; i++) msgq.push_back(8'(i + 8'h30));
        build_expect();
        void'(sb.pop_back());
        send_msg(lat);
        repeat (3) @(negedge clock);
        checks++;
        if (blk_first !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_wait: first %b ready %b want 1 0",
                     blk_first, in_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({in_ready, blk_start, blk_first, blk_final, msg_done} !== 5'b0) begin
            errors++;
            $display("FAIL abort_outs: got %b want 00000",
                     {in_ready, blk_start, blk_first, blk_final, msg_done});
        end
        checks++;
        if (blk_data !== 512'b0) begin
            errors++;
            $display("FAIL abort_data: got %h want 0", blk_data);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        s0 = nstart;
        repeat (5) @(negedge clock);
        checks++;
        if (nstart != s0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle: starts %0d ready %b want 0 1",
                     nstart - s0, in_ready);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL abort_sb: %0d blocks left want 0", sb.size());
        end
        auto_fin = 1;
        test_abc();
    endtask

    initial begin
        test_reset();
        test_abc();
        test_len55();
        test_len56();
        test_len64_holdoff();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
Front end for the sha256 core. Accepts a byte stream (valid/ready plus last) and applies standard SHA-256 padding: a 0x80 byte, zero fill, then the 64-bit big-endian message bit length. It emits 512-bit blocks to the core over the core's start/block/finish interface. It issues one block at a time and waits for the core's finish pulse before issuing the next.

Parameters:
LEN_W, 64, width of the internal message bit-length counter (legal 16..64); zero-extended into the 64-bit length field.

Ports:
clock  input  1  single clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  byte available on in_data
in_data  input  8  message byte
in_last  input  1  qualifies in_data as final byte of message
in_ready  output  1  padder accepts byte this cycle
blk_start  output  1  one-cycle pulse: blk_data valid, core may begin
blk_data  output  512  block; byte 0 at [511:504], byte 63 at [7:0]
blk_first  output  1  block is first of a message (core loads IV); valid while blk_data held
blk_final  output  1  block is last of a message; valid while blk_data held
blk_finish  input  1  core done with current block (pulse)
msg_done  output  1  one-cycle pulse after core finishes final block

Behaviour:
- Reset (async, reset=0): state FILL, buffer=0, idx=0, bitlen=0, first flag=1, all outputs 0 except in_ready=1 once reset deasserts. Reset mid-block or mid-wait abandons the message; no further blk_start until new bytes arrive.
- Buffer cleared to all-zero whenever a new block begins, so zero fill is implicit.
- Transfer happens when in_valid and in_ready are both high at a clock edge. in_ready=1 only in state FILL.
- FILL, on transfer: write the byte at index idx; bitlen += 8, modulo 2^LEN_W.
  - If idx==63: go to ISSUE. If in_last is also set, set pad_pending.
  - Else if in_last: idx++, go to PAD.
  - Else: idx++.
- PAD (one cycle): write 0x80 at idx.
  - If idx<=55: write the 64-bit length into bytes 56..63, final=1.
  - Else: set len_pending, final=0.
  - Then go to ISSUE.
- LEN (one cycle): buffer is already zero; write the length into bytes 56..63, final=1, go to ISSUE.
- ISSUE: blk_start=1 for exactly one cycle; blk_first/blk_final driven; go to WAIT.
- WAIT: blk_data, blk_first and blk_final are held stable. blk_finish is ignored in every state except WAIT, including the ISSUE cycle. On blk_finish:
  - final=1: msg_done=1 next cycle; reset bitlen, idx, first=1, flags; go to FILL.
  - pad_pending: clear buffer, idx=0, first=0; go to PAD.
  - len_pending: clear buffer, first=0; go to LEN.
  - otherwise: clear buffer, idx=0, first=0; go to FILL.
- Latency: last byte accepted at edge k means blk_start is high in cycle k+2 (PAD then ISSUE). A full 64-byte block without last gives blk_start in cycle k+1.
- Zero-length messages are not supported; every message carries at least one byte with in_last.
- in_last without in_valid has no effect.

Test Plan:
- "abc" (0x61,0x62,0x63 with last) -> one block; bytes 0..3 = 61 62 63 80, bytes 4..62 = 0, byte 63 = 0x18; blk_first=blk_final=1; blk_start 2 cycles after last accept.
- 55-byte message -> single block; byte 55 = 0x80; length field = 0x00000000000001B8.
- 56-byte message -> block 1: byte 56 = 0x80, rest zero, blk_final=0. Block 2: all zero except length 0x1C0, blk_first=0, blk_final=1.
- 64-byte message -> block 1 = data only, blk_final=0. Block 2: byte 0 = 0x80, length 0x200. Finish held off 20 cycles: in_ready stays 0, blk_data stays stable, exactly one blk_start per block.
- Back-to-back messages "a" then "b" with blk_finish delayed 5 cycles -> two single-block messages, each with blk_first=1 and one msg_done pulse.
- Assert reset low in WAIT of a 2-block message -> all outputs 0 immediately. After release, "abc" gives the correct single block with bitlen restarted from 0.
